// File: rtl/mac_accum.sv
// mac_accum: LEN-term unsigned dot product onto a bias, with a registered multiply and valid/ready streams.
// Define MAC_ACCUM_SAT_EN to saturate the accumulator and expose a sticky ovf flag; otherwise it wraps.
module mac_accum #(
  parameter int DATA_W = 8,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 24,
  parameter int LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BIAS_W-1:0] b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  output logic              busy
`ifdef MAC_ACCUM_SAT_EN
  ,
  output logic              ovf
`endif
);
  localparam int CW = $clog2(LEN + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [2*DATA_W-1:0] prod;
  logic [CW-1:0] cnt;
  logic pvld, beat, last;
  assign in_ready = state_q == ACCUM;
  assign busy = state_q != IDLE;
  assign beat = in_valid && in_ready;
  assign last = cnt == CW'(LEN - 1);
`ifdef MAC_ACCUM_SAT_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nx = acc + ACC_W'(prod);
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ACCUM : IDLE;
      ACCUM:   state_d = (beat && last) ? DRAIN : ACCUM;
      DRAIN:   state_d = DONE;
      default: state_d = (out_valid && out_ready) ? IDLE : DONE;
    endcase
  end
  // out is its own register so it survives the bias load of the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc       <= '0;
      prod      <= '0;
      cnt       <= '0;
      pvld      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
`ifdef MAC_ACCUM_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pvld    <= beat;
      if (state_q == IDLE && start) begin
        acc <= ACC_W'(b);
        cnt <= '0;
`ifdef MAC_ACCUM_SAT_EN
        ovf <= 1'b0;
`endif
      end else if (pvld) begin
        acc <= acc_nx;
`ifdef MAC_ACCUM_SAT_EN
        if (sum[ACC_W]) ovf <= 1'b1;
`endif
      end
      if (beat) begin
        prod <= (2*DATA_W)'(in) * (2*DATA_W)'(w);
        cnt  <= cnt + 1'b1;
      end
      if (state_q == DONE && !out_valid) begin
        out_valid <= 1'b1;
        out       <= acc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
